// File: rtl/tone_period_meter.sv
// Recovers the half-wave period of a tone-style square wave in enable ticks,
// with lock tracking and loss-of-signal timeout. States: ACQUIRE | TRACK | LOCKED.
module tone_period_meter #(
    parameter int PERIOD_BITS = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   tone_in,
    output logic [PERIOD_BITS-1:0] period,
    output logic                   period_valid,
    output logic                   locked,
    output logic                   timeout
);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [PERIOD_BITS-1:0] CNT_MAX = '1;
    localparam logic [PERIOD_BITS-1:0] CNT_ONE = PERIOD_BITS'(1);

    state_t                 r_state;
    logic                   r_sample;
    logic [PERIOD_BITS-1:0] r_cnt;
    logic [PERIOD_BITS-1:0] r_prev;
    logic                   r_have_prev;
    logic [PERIOD_BITS-1:0] r_period;
    logic                   r_valid;
    logic                   r_locked;
    logic                   r_timeout;

    logic                   w_edge;
    logic                   w_cnt_max;
    logic [PERIOD_BITS-1:0] w_cnt_inc;

    assign w_edge    = (tone_in != r_sample);
    assign w_cnt_max = (r_cnt == CNT_MAX);
    assign w_cnt_inc = r_cnt + CNT_ONE;

    assign period       = r_period;
    assign period_valid = r_valid;
    assign locked       = r_locked;
    assign timeout      = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACQUIRE;
            r_sample    <= 1'b1;
            r_cnt       <= '0;
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_period    <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            if (enable) begin
                r_sample <= tone_in;
                case (r_state)
                    ST_ACQUIRE: begin
                        // Counter phase is unknown here, so the first edge only aligns it.
                        r_locked <= 1'b0;
                        if (w_edge) begin
                            r_cnt   <= CNT_ONE;
                            r_state <= ST_TRACK;
                        end else if (!w_cnt_max) begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_TRACK: begin
                        if (w_edge) begin
                            r_period    <= r_cnt;
                            r_valid     <= 1'b1;
                            r_prev      <= r_cnt;
                            r_have_prev <= 1'b1;
                            r_cnt       <= CNT_ONE;
                            if (r_have_prev && (r_cnt == r_prev)) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else if (w_cnt_max) begin
                            r_timeout   <= 1'b1;
                            r_state     <= ST_ACQUIRE;
                            r_locked    <= 1'b0;
                            r_have_prev <= 1'b0;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_edge) begin
                            r_period <= r_cnt;
                            r_valid  <= 1'b1;
                            r_cnt    <= CNT_ONE;
                            if (r_cnt != r_prev) begin
                                r_state  <= ST_TRACK;
                                r_locked <= 1'b0;
                                r_prev   <= r_cnt;
                            end
                        end else if (w_cnt_max) begin
                            r_timeout   <= 1'b1;
                            r_state     <= ST_ACQUIRE;
                            r_locked    <= 1'b0;
                            r_have_prev <= 1'b0;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state     <= ST_ACQUIRE;
                        r_locked    <= 1'b0;
                        r_have_prev <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Bench for tone_period_meter: vector table, tone-generator scenarios and random
// stimulus, all checked cycle by cycle against a tick-index reference model.
module tb_tone_period_meter;

    localparam int PB   = 12;
    localparam int MAXV = (1 << PB) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          tone_in = 1'b1;
    logic [PB-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          timeout;

    always #5 clk = ~clk;

    tone_period_meter #(.PERIOD_BITS(PB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .tone_in      (tone_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: measurements are differences of enable-tick indices at
    // which edges were seen; lock means the last two measurements of the current
    // acquisition are equal.
    bit m_sample, m_acq, m_pv, m_to, m_locked;
    int m_tick, m_last, m_period;
    int m_meas[$];

    function automatic void model_reset();
        m_sample = 1'b1; m_acq = 1'b1; m_pv = 1'b0; m_to = 1'b0; m_locked = 1'b0;
        m_tick = 0; m_last = 0; m_period = 0;
        m_meas.delete();
    endfunction

    function automatic void model_tick(bit en, bit tone);
        bit e;
        int d;
        m_pv = 1'b0;
        m_to = 1'b0;
        if (!en) return;
        e = (tone != m_sample);
        m_sample = tone;
        m_tick++;
        if (m_acq) begin
            if (e) begin
                m_acq = 1'b0;
                m_last = m_tick;
                m_meas.delete();
            end
            m_locked = 1'b0;
        end else begin
            d = m_tick - m_last;
            if (e) begin
                m_period = d;
                m_pv = 1'b1;
                m_meas.push_back(d);
                m_last = m_tick;
                m_locked = (m_meas.size() >= 2) && (m_meas[m_meas.size()-1] == m_meas[m_meas.size()-2]);
            end else if (d == MAXV) begin
                m_to = 1'b1;
                m_acq = 1'b1;
                m_locked = 1'b0;
            end
        end
    endfunction

    int pv_cyc[$];
    int pv_per[$];
    bit pv_lock[$];
    int to_n;

    task automatic clear_stats();
        pv_cyc.delete(); pv_per.delete(); pv_lock.delete(); to_n = 0;
    endtask

    task automatic step(input bit en, input bit tone);
        enable  = en;
        tone_in = tone;
        @(posedge clk);
        model_tick(en, tone);
        cyc++;
        #1;
        check("period", int'(period), m_period);
        check("period_valid", int'(period_valid), int'(m_pv));
        check("locked", int'(locked), int'(m_locked));
        check("timeout", int'(timeout), int'(m_to));
        if (period_valid) begin
            pv_cyc.push_back(cyc);
            pv_per.push_back(int'(period));
            pv_lock.push_back(locked);
        end
        if (timeout) to_n++;
    endtask

    bit tg_tone;
    int tg_cnt;

    task automatic tg_step(input int n, input bit en);
        step(en, tg_tone);
        if (en) begin
            tg_cnt++;
            if (tg_cnt >= n) begin
                tg_tone = ~tg_tone;
                tg_cnt  = 0;
            end
        end
    endtask

    task automatic run_tg(input int n, input int cycles, input int en_every);
        for (int i = 0; i < cycles; i++) tg_step(n, (i % en_every) == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; tone_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        check("rst_period", int'(period), 0);
        check("rst_valid", int'(period_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        tg_tone = 1'b1;
        tg_cnt  = 0;
        clear_stats();
    endtask

    task automatic check_gaps(input string name, input int gap);
        for (int i = 1; i < pv_cyc.size(); i++) check(name, pv_cyc[i] - pv_cyc[i-1], gap);
    endtask

    typedef struct {
        bit en;
        bit tone;
        bit pv;
        int per;
        bit lk;
        bit to;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int guard;
        int zeros;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0};

        model_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en, vecs[i].tone);
            check("vec_period", int'(period), vecs[i].per);
            check("vec_valid", int'(period_valid), int'(vecs[i].pv));
            check("vec_locked", int'(locked), int'(vecs[i].lk));
            check("vec_timeout", int'(timeout), int'(vecs[i].to));
        end

        // P=4, enable every cycle
        do_reset();
        run_tg(4, 40, 1);
        check("p4_pulses", int'(pv_cyc.size() >= 7), 1);
        check_gaps("p4_gap", 4);
        if (pv_lock.size() >= 2) begin
            check("p4_lock_first", int'(pv_lock[0]), 0);
            check("p4_lock_second", int'(pv_lock[1]), 1);
        end
        check("p4_period", int'(period), 4);
        check("p4_locked", int'(locked), 1);

        // P=4 -> P=8 mid-wave
        clear_stats();
        run_tg(8, 60, 1);
        zeros = 0;
        foreach (pv_lock[i]) if (!pv_lock[i]) zeros++;
        check("p8_lock_dropped", int'(zeros >= 1), 1);
        check("p8_period", int'(period), 8);
        check("p8_locked", int'(locked), 1);

        // constant tone after lock
        clear_stats();
        repeat (4100) step(1'b1, tg_tone);
        check("to_count", to_n, 1);
        check("to_locked", int'(locked), 0);
        check("to_period_held", int'(period), 8);
        clear_stats();
        tg_tone = ~tg_tone;
        repeat (6) step(1'b1, tg_tone);
        check("to_next_edge_discarded", pv_cyc.size(), 0);

        // P=0 and P=1 both toggle every tick
        for (int p = 0; p < 2; p++) begin
            do_reset();
            run_tg((p < 1) ? 1 : p, 20, 1);
            check("p01_pulses", int'(pv_cyc.size() >= 15), 1);
            check_gaps("p01_gap", 1);
            check("p01_period", int'(period), 1);
            check("p01_locked", int'(locked), 1);
        end

        // P=4095 with enable every 3rd cycle
        do_reset();
        run_tg(MAXV, 4 * MAXV * 3 + 30, 3);
        check("p4095_pulses", pv_cyc.size(), 3);
        check_gaps("p4095_gap", 3 * MAXV);
        check("p4095_timeouts", to_n, 0);
        check("p4095_period", int'(period), MAXV);
        check("p4095_locked", int'(locked), 1);

        // async reset halfway through a P=100 high half-wave
        do_reset();
        guard = 0;
        while (!(locked && tg_tone && tg_cnt == 50) && guard < 3000) begin
            tg_step(100, 1'b1);
            guard++;
        end
        check("rst_setup_bound", int'(guard < 3000), 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_period", int'(period), 0);
        check("async_valid", int'(period_valid), 0);
        check("async_locked", int'(locked), 0);
        check("async_timeout", int'(timeout), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_stats();
        guard = 0;
        while (pv_cyc.size() < 1 && guard < 400) begin
            tg_step(100, 1'b1);
            guard++;
        end
        check("rst_relock_bound", int'(guard < 400), 1);
        if (pv_per.size() > 0) check("rst_first_meas", pv_per[0], 100);

        // randomized segments
        do_reset();
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(5, 40)) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                tg_tone = tone_in;
            end else begin
                int n  = $urandom_range(1, 12);
                int ee = $urandom_range(1, 3);
                run_tg(n, $urandom_range(20, 120), ee);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tone_period_meter.md
# tone_period_meter

Measures the half-wave period of a square wave produced by a `tone` generator (or any tone-style source on the same clock), expressed in enable ticks. This is the inverse of the tone generator: it recovers the period register value from the waveform. It sits on the PSG test and loopback path, where it checks generator channels and decodes externally supplied tone signals. It reports each measured half-period with a one-cycle valid pulse, tracks lock (stable period), and flags loss of signal.

## Interface
- `PERIOD_BITS`, 12, width of the measured period and of the internal tick counter.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  tick strobe. It is the same strobe that advances the tone generators; all state advances only on cycles with `enable`=1.
- `tone_in`  in  1  square wave input. It is synchronous to `clk`; the block does no synchronizing.
- `period`  out  PERIOD_BITS  last measured half-period in enable ticks.
- `period_valid`  out  1  one-cycle pulse when `period` is updated.
- `locked`  out  1  high while consecutive measurements are equal.
- `timeout`  out  1  one-cycle pulse when no edge arrives within 2^PERIOD_BITS-1 ticks.

## Operation
- Registers: `sample` (last sampled `tone_in`), `cnt` (PERIOD_BITS bits), `prev` (last measurement), FSM state.
- Reset values: `sample`=1, which matches the tone flip-flop reset state. All other registers reset to 0: `cnt`, `prev`, `period`, `period_valid`, `locked`, `timeout`. State resets to ACQUIRE.
- Edge definition: on an enable tick, an edge occurs when `tone_in` != `sample`. `sample` <= `tone_in` on every enable tick.
- Counter rule on an enable tick:
  - edge: `cnt` <= 1.
  - no edge: `cnt` <= `cnt`+1.
  - The measurement taken at an edge is the pre-update `cnt`.
- A source toggling every N ticks gives measurement N. A tone generator period of 0 or 1 gives 1. Period 4095 gives 4095.
- FSM states: ACQUIRE, TRACK, LOCKED.
  - ACQUIRE: on an edge, go to TRACK. No measurement is made, because the counter phase is unknown; the first edge is always discarded. `locked`=0.
  - TRACK: on an edge, `period` <= `cnt`, pulse `period_valid`, `prev` <= `cnt`. If a previous measurement exists and `cnt`==`prev`, go to LOCKED and set `locked`=1.
  - LOCKED: on an edge, `period` <= `cnt` and pulse `period_valid`. If `cnt`!=`prev`, go to TRACK, clear `locked`, and set `prev` <= `cnt`.
  - "Previous measurement exists" is a flag. It is set by the first TRACK measurement and cleared on entry to ACQUIRE.
- Timeout: in TRACK or LOCKED, an enable tick with no edge and `cnt`==2^PERIOD_BITS-1 does the following:
  - pulses `timeout` and goes to ACQUIRE;
  - clears `locked` and the prev-exists flag;
  - `cnt` <= 0;
  - `period` holds its last value.
- In ACQUIRE, `cnt` saturates at 2^PERIOD_BITS-1 and `timeout` never fires.
- `enable`=0: all registers hold, except `period_valid` and `timeout`, which return to 0.

## Timing
- All outputs are registered. `period`, `period_valid`, `locked` and the new state become visible in the cycle after the enable tick that detects the edge.
- Detection delay: an edge on `tone_in` is seen at the next enable tick. The total latency from a `tone_in` change to `period_valid` is (cycles to next enable tick) + 1.
- `period_valid` and `timeout` are high for exactly one clock, even when `enable` is high on consecutive cycles.
- `period_valid` and `timeout` are mutually exclusive, because timeout requires the no-edge condition.
- Asynchronous reset mid-measurement forces all reset values immediately. After `rst_n` is released, the first edge is discarded as in ACQUIRE.
- Lock requires two equal consecutive measurements: the earliest `locked`=1 is at the third detected edge after reset.

## Test plan
- Tone generator with P=4, `enable`=1 every cycle:
  - the first edge gives no pulse;
  - then `period_valid` pulses every 4 cycles with `period`=4;
  - `locked` rises with the second pulse and stays high.
- P=0, then a separate run with P=1: every measurement is 1; `locked`=1; `period_valid` pulses every cycle.
- Locked at P=4, then P is written to 8 mid-wave:
  - one intermediate measurement drops `locked` to 0;
  - then two measurements of 8 re-lock.
- Constant `tone_in` after lock:
  - after 4095 no-edge ticks, `timeout` pulses once and `locked`=0;
  - `period` keeps its old value;
  - the next edge is discarded.
- P=4095 with `enable` every 3rd cycle:
  - `period`=4095 with no timeout;
  - pulses are 12285 clocks apart;
  - `enable`=0 gaps do not change `cnt`.
- Assert `rst_n` low halfway through a P=100 half-wave:
  - all outputs go to 0 immediately;
  - after release, the first edge is discarded and the next valid measurement is 100.
